key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 9 +
 rtl/sync_2ff.sv | 15 +
 rtl/key_debounce.sv | 63 ++++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: state encoding and default filter length shared by the key debouncer
package key_pkg;
    typedef logic [1:0] state_t;
    localparam state_t UP      = 2'd0;
    localparam state_t FILT_DN = 2'd1;
    localparam state_t DOWN    = 2'd2;
    localparam state_t FILT_UP = 2'd3;
    localparam int CNT_MAX_DEFAULT = 1_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit with a configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer with press/release pulses and an LED select toggle
module key_debounce
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic led_sel
);
    localparam int CW = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
    logic key_s;
    logic done;
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (key_in),
        .q  (key_s)
    );
    assign done = cnt == LAST;
    // cnt is held at zero outside the filter states so every qualification starts fresh
    always_comb begin
        nxt = state;
        cnt_nxt = '0;
        case (state)
            UP:      nxt = key_s ? UP : FILT_DN;
            FILT_DN: begin
                nxt = key_s ? UP : (done ? DOWN : FILT_DN);
                cnt_nxt = (key_s || done) ? '0 : cnt + 1'b1;
            end
            DOWN:    nxt = key_s ? FILT_UP : DOWN;
            FILT_UP: begin
                nxt = !key_s ? DOWN : (done ? UP : FILT_UP);
                cnt_nxt = (!key_s || done) ? '0 : cnt + 1'b1;
            end
            default: nxt = UP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UP;
            cnt <= '0;
            key_level <= 1'b1;
            key_press <= 1'b0;
            key_release <= 1'b0;
            led_sel <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= cnt_nxt;
            key_level <= nxt == UP || nxt == FILT_DN;
            key_press <= state == FILT_DN && nxt == DOWN;
            key_release <= state == FILT_UP && nxt == UP;
            if (state == FILT_DN && nxt == DOWN) led_sel <= ~led_sel;
        end
    end
endmodule
